// File: rtl/serdet_pkg.sv
// Shared state encodings for the round-robin serial detector front-end.
package serdet_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StResult = 2'd2
    } sched_state_e;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } det_state_e;

endpackage

// File: rtl/serial_pattern_det.sv
// Bit-serial pattern detector FSM; y is high while in S4. clr overrides x.
module serial_pattern_det
    import serdet_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic x,
    output logic y
);

    det_state_e state_q, state_d;

    always_comb begin
        state_d = S0;
        if (!clr) begin
            case (state_q)
                S0:      state_d = x ? S1 : S2;
                S1:      state_d = x ? S0 : S5;
                S2:      state_d = x ? S1 : S3;
                S3:      state_d = x ? S4 : S3;
                S4:      state_d = x ? S3 : S4;
                S5:      state_d = x ? S0 : S4;
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign y = (state_q == S4);

endmodule

// File: rtl/serdet_rr_scheduler.sv
// Round-robin arbiter that serializes granted words MSB-first into one detector lane.
// Optional macro SERDET_STICKY_HIT_EN: hit reports acceptance after any prefix of the word.
module serdet_rr_scheduler
    import serdet_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] word_in,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic                    hit
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    sched_state_e      state_q;
    logic [WORD_W-1:0] sreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   ptr_q;
    logic [N_REQ-1:0]  ack_q;

    logic              any_req;
    logic              grant_now;
    logic [ID_W-1:0]   pick_idx;
    logic              det_y;

    // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        int   idx;
        logic found;
        found    = 1'b0;
        pick_idx = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                pick_idx = ID_W'(idx);
            end
        end
    end

    assign any_req   = |req;
    assign grant_now = (state_q == StIdle) && any_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            ack_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        sreg_q  <= word_in[int'(pick_idx)*WORD_W +: WORD_W];
                        grant_q <= pick_idx;
                        ptr_q   <= pick_idx;
                        cnt_q   <= '0;
                        ack_q   <= N_REQ'(1) << pick_idx;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    sreg_q <= sreg_q << 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WORD_W - 1)) begin
                        state_q <= StResult;
                    end
                end
                StResult: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // The detector free-runs outside SHIFT; it is cleared at every grant so the drift is harmless.
    serial_pattern_det u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (grant_now),
        .x     (sreg_q[WORD_W-1]),
        .y     (det_y)
    );

    assign ack     = ack_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StResult);
    assign done_id = done ? grant_q : '0;

`ifdef SERDET_STICKY_HIT_EN
    logic sticky_q;

    // y during SHIFT reflects the previous edge's next state; y in RESULT covers the last edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (grant_now) begin
            sticky_q <= 1'b0;
        end else if (state_q == StShift && det_y) begin
            sticky_q <= 1'b1;
        end
    end

    assign hit = done && (sticky_q || det_y);
`else
    assign hit = done && det_y;
`endif

endmodule

// File: tb/tb_serdet_rr_scheduler.sv
// Scoreboard bench for serdet_rr_scheduler: stimulus pushes expectations, a monitor checks them.
module tb_serdet_rr_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 8;
    localparam int ID_W   = 2;

`ifdef SERDET_STICKY_HIT_EN
    localparam logic HIT_03 = 1'b1;
`else
    localparam logic HIT_03 = 1'b0;
`endif

    typedef struct {
        int   id;
        logic hit;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*WORD_W-1:0] word_in = '0;
    logic [N_REQ-1:0]        ack;
    logic                    busy;
    logic                    done;
    logic [ID_W-1:0]         done_id;
    logic                    hit;

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    int   ack_cyc = 0;
    int   exp_ack_q[$];
    exp_t exp_done_q[$];

    serdet_rr_scheduler #(
        .N_REQ  (N_REQ),
        .WORD_W (WORD_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .word_in (word_in),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .hit     (hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack/done the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack != '0) begin
                if (exp_ack_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    int id;
                    id = exp_ack_q.pop_front();
                    check("ack_onehot", 32'(ack), 32'd1 << id);
                    ack_cyc = cyc;
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_done_q.pop_front();
                    check("done_id", 32'(done_id), 32'(e.id));
                    check("hit", 32'(hit), 32'(e.hit));
                    check("latency", 32'(cyc - ack_cyc), 32'(WORD_W));
                end
            end else if (hit || done_id != '0) begin
                check("idle_outputs", {30'd0, hit, 1'b0} | 32'(done_id), 32'd0);
            end
        end
    end

    task automatic expect_word(input int id, input logic h);
        exp_t e;
        e.id  = id;
        e.hit = h;
        exp_ack_q.push_back(id);
        exp_done_q.push_back(e);
    endtask

    task automatic wait_ack(input int id);
        int n = 0;
        @(negedge clk);
        while (!ack[id] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ack[id]) check("ack_timeout", 32'(ack[id]), 32'd1);
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        dc = cyc;
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic single(input int id, input logic [7:0] w, input logic h);
        int dc;
        word_in[id*WORD_W +: WORD_W] = w;
        req = N_REQ'(1) << id;
        expect_word(id, h);
        wait_ack(id);
        req = '0;
        wait_done(dc);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int dc [5];
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        single(0, 8'h01, 1'b1);
        single(0, 8'h00, 1'b0);
        single(0, 8'h80, 1'b1);
        single(0, 8'h03, HIT_03);

        // All requesters held from reset: strict rotation 0,1,2,3,0.
        do_reset();
        word_in = {8'h03, 8'h80, 8'h00, 8'h01};
        expect_word(0, 1'b1);
        expect_word(1, 1'b0);
        expect_word(2, 1'b1);
        expect_word(3, HIT_03);
        expect_word(0, 1'b1);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) wait_done(dc[i]);
        wait_ack(0);
        req = '0;
        wait_done(dc[4]);
        for (int i = 0; i < 4; i++) check("done_spacing", 32'(dc[i+1] - dc[i]), 32'd10);
        @(negedge clk);

        // req[1] held, req[3] raised during req[1]'s SHIFT: 3 must win next.
        do_reset();
        word_in = {8'h03, 8'h80, 8'h00, 8'h01};
        expect_word(1, 1'b0);
        expect_word(3, HIT_03);
        req = 4'b0010;
        wait_ack(1);
        @(negedge clk);
        req = 4'b1010;
        wait_ack(3);
        req = '0;
        wait_done(dc[0]);
        @(negedge clk);

        // Reset during the 4th SHIFT cycle drops the word.
        do_reset();
        word_in = {8'h03, 8'h80, 8'h00, 8'h01};
        exp_ack_q.push_back(2);
        req = 4'b0100;
        wait_ack(2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req   = '0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_word(0, 1'b1);
        expect_word(2, 1'b1);
        req = 4'b0101;
        wait_ack(0);
        req = 4'b0100;
        wait_ack(2);
        req = '0;
        wait_done(dc[0]);
        repeat (3) @(negedge clk);

        check("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
